// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide sequencer owning the HI/LO registers.
// Executes MULTU/MULT/DIVU/DIV in IDLE -> PREP -> RUN (ITER cycles) -> FIX -> DONE.
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   start, op, a, b    operation request (op: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV)
//   rd_hilo            MFHI/MFLO in execute (only affects stall)
//   we_hi, we_lo, wd   MTHI/MTLO writes, honoured in IDLE and DONE only
//   hi, lo             HI/LO registers
//   busy, done         operation in flight / one-cycle result-valid pulse
//   stall              combinational stall request to the pipeline
module mdu_seq #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        rd_hilo,
  input  logic        we_hi,
  input  logic        we_lo,
  input  logic [31:0] wd,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam int unsigned CW = $clog2(ITER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   opd_q, opd_d;      // |multiplicand| or |divisor|
  logic [63:0]   acc_q, acc_d;      // mult: {partial, multiplier}; div: {remainder, quotient}
  logic          neg_res_q, neg_res_d;
  logic          neg_rem_q, neg_rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic          is_div;
  logic          is_signed;
  logic [31:0]   abs_a;
  logic [31:0]   abs_b;
  logic [32:0]   mul_sum;
  logic [63:0]   mul_step;
  logic [32:0]   div_top;
  logic [33:0]   div_diff;
  logic          div_ge;
  logic [63:0]   div_step;
  logic [63:0]   prod_fix;
  logic [31:0]   quo_fix;
  logic [31:0]   rem_fix;

  assign is_div    = op_q[1];
  assign is_signed = op_q[0];

  // Negating 32'h80000000 wraps to itself, which is the correct unsigned magnitude.
  assign abs_a = (is_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
  assign abs_b = (is_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;

  // Shift-add: add multiplicand into the upper half when the multiplier LSB is set,
  // then shift the whole 65-bit {carry, acc} right by one.
  assign mul_sum  = {1'b0, acc_q[63:32]} + {1'b0, (acc_q[0] ? opd_q : 32'd0)};
  assign mul_step = {mul_sum, acc_q[31:1]};

  // Restoring divide: shift next dividend bit into the remainder, subtract if it fits.
  // With a zero divisor every step subtracts, giving quotient all-ones.
  assign div_top  = {acc_q[63:32], acc_q[31]};
  assign div_diff = {1'b0, div_top} - {2'b00, opd_q};
  assign div_ge   = ~div_diff[33];
  assign div_step = div_ge ? {div_diff[31:0], acc_q[30:0], 1'b1}
                           : {div_top[31:0],  acc_q[30:0], 1'b0};

  assign prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
  assign quo_fix  = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      opd_q     <= '0;
      acc_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opd_q     <= opd_d;
      acc_q     <= acc_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    opd_d     = opd_q;
    acc_d     = acc_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          state_d = S_PREP;
        end else begin
          if (we_hi) hi_d = wd;
          if (we_lo) lo_d = wd;
          state_d = S_IDLE;
        end
      end
      S_PREP: begin
        acc_d     = {32'd0, abs_a};
        opd_d     = abs_b;
        neg_res_d = is_signed & (a_q[31] ^ b_q[31]);
        neg_rem_d = is_signed & a_q[31];
        cnt_d     = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        acc_d = is_div ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (!is_div) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (b_q == 32'd0) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == S_PREP) || (state_q == S_RUN) || (state_q == S_FIX);
  assign done  = (state_q == S_DONE);
  assign stall = busy & (start | rd_hilo | we_hi | we_lo);

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_hilo;
  logic        we_hi;
  logic        we_lo;
  logic [31:0] wd;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  mdu_seq #(.ITER(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .rd_hilo (rd_hilo),
    .we_hi   (we_hi),
    .we_lo   (we_lo),
    .wd      (wd),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .stall   (stall)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [63:0] exp_q[$];
  int unsigned t0;
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'd0: return {32'd0, x} * {32'd0, y};
      2'd1: return 64'(sx * sy);
      2'd2: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        return {x % y, x / y};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFFFFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Drive a request for one edge, then scramble op/a/b to show they are sampled only at accept.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] expv);
    exp_q.push_back(expv);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    t0    = cyc;
    op    = ~o;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_done(input string tag);
    int n;
    logic [63:0] e;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, " done"}, done, 1);
    chk({tag, " latency"}, cyc - t0, 34);
    chk({tag, " busy_low"}, busy, 0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      last_hi = e[63:32];
      last_lo = e[31:0];
      chk({tag, " hi"}, hi, e[63:32]);
      chk({tag, " lo"}, lo, e[31:0]);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dn;
    logic [1:0]  ro;
    logic [31:0] rx, ry;

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    rd_hilo = 1'b0; we_hi = 1'b0; we_lo = 1'b0; wd = '0;
    tick();
    tick();
    reset = 1'b0;
    chk("reset hi", hi, 0);
    chk("reset lo", lo, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset stall", stall, 0);

    // Directed arithmetic cases
    issue(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001});
    chk("multu busy_after_accept", busy, 1);
    wait_done("multu_max");
    tick();
    chk("multu done_pulse_len", done, 0);

    issue(2'd1, -32'sd3, 32'd7, {32'hFFFFFFFF, 32'hFFFFFFEB});
    wait_done("mult_neg");
    tick();
    issue(2'd3, -32'sd7, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD});
    wait_done("div_neg");
    tick();
    issue(2'd2, 32'd100, 32'd0, {32'd100, 32'hFFFFFFFF});
    wait_done("divu_by0");
    tick();
    issue(2'd3, -32'sd100, 32'd0, {32'hFFFFFF9C, 32'hFFFFFFFF});
    wait_done("div_by0_neg");
    tick();
    issue(2'd3, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000});
    wait_done("div_ovf");
    tick();

    // Requests while busy: stall raised, nothing written, no new op
    issue(2'd0, 32'd12345, 32'd10, {32'd0, 32'd123450});
    tick();
    tick();
    tick();
    chk("busy_idle_req stall", stall, 0);
    rd_hilo = 1'b1;
    #1 chk("stall rd_hilo", stall, 1);
    tick();
    rd_hilo = 1'b0;
    we_hi = 1'b1;
    wd = 32'd5;
    #1 chk("stall we_hi", stall, 1);
    tick();
    we_hi = 1'b0;
    chk("busy mthi ignored", hi, {32'd0, last_hi});
    start = 1'b1;
    op = 2'd2;
    a = 32'd1;
    b = 32'd1;
    #1 chk("stall start", stall, 1);
    tick();
    start = 1'b0;
    chk("busy lo held", lo, {32'd0, last_lo});
    wait_done("op_during_stall");
    we_hi = 1'b1;
    wd = 32'd5;
    tick();
    we_hi = 1'b0;
    chk("mthi_in_done hi", hi, 5);
    chk("mthi_in_done lo", lo, 123450);
    we_hi = 1'b1;
    we_lo = 1'b1;
    wd = 32'hA5A5_0F0F;
    tick();
    we_hi = 1'b0;
    we_lo = 1'b0;
    chk("idle both_wr hi", hi, 32'hA5A5_0F0F);
    chk("idle both_wr lo", lo, 32'hA5A5_0F0F);

    // Reset in the middle of RUN aborts with no partial result
    issue(2'd0, 32'd1000, 32'd1000, {32'd0, 32'd1000000});
    tick();
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    void'(exp_q.pop_front());
    chk("midrun_reset busy", busy, 0);
    chk("midrun_reset done", done, 0);
    chk("midrun_reset hi", hi, 0);
    chk("midrun_reset lo", lo, 0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done === 1'b1) dn++;
    end
    chk("midrun_reset no_done", dn, 0);
    issue(2'd0, 32'd6, 32'd7, {32'd0, 32'd42});
    wait_done("multu_after_reset");
    tick();

    // Start held in DONE is accepted immediately
    issue(2'd0, 32'd3, 32'd5, {32'd0, 32'd15});
    wait_done("chain_first");
    exp_q.push_back({32'd1, 32'd2});
    op = 2'd2;
    a = 32'd9;
    b = 32'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    chk("chain accept_edge", cyc - t0, 35);
    chk("chain busy", busy, 1);
    t0 = cyc;
    wait_done("chain_divu");
    tick();

    // start beats we_lo in IDLE
    we_lo = 1'b1;
    wd = 32'hDEADBEEF;
    issue(2'd1, 32'd2, -32'sd4, {32'hFFFFFFFF, 32'hFFFFFFF8});
    we_lo = 1'b0;
    chk("start_prio lo", lo, 2);
    wait_done("start_prio_op");
    tick();

    // Random operands checked against the bench model
    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = $urandom;
      ry = (i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom;
      if (i % 4 == 1) rx = -rx;
      issue(ro, rx, ry, model(ro, rx, ry));
      wait_done("random");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
